// File: rtl/aes_128_sched.sv
// aes_128_sched: round-robin issue of NUM_REQ requesters into one pipelined aes_128 core,
// with a tag pipeline of matching depth that routes each ciphertext back to its owner.
module aes_128_sched #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 21
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*128-1:0]       req_state,
   input  logic [NUM_REQ*128-1:0]       req_key,
   output logic [127:0]                 core_state,
   output logic [127:0]                 core_key,
   input  logic [127:0]                 core_out,
   output logic [NUM_REQ-1:0]           resp_valid,
   output logic [127:0]                 resp_data,
   output logic [$clog2(LATENCY+1)-1:0] in_flight,
   output logic                         busy
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(LATENCY+1);
   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_found;
   logic               transfer;
   logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
   logic [IDX_W-1:0]   tag_idx_q [LATENCY];
   logic [IDX_W-1:0]   tag_idx_d [LATENCY];
   logic [CNT_W-1:0]   in_flight_q, in_flight_d;

   // First valid requester at or after ptr, searching with wrap-around.
   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      grant_found = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
         cand = sum[IDX_W-1:0];
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign transfer = rst_n & en & grant_found;

   // Idle core inputs are forced to zero so the core never sees stale requester data.
   always_comb begin
      req_ready  = '0;
      core_state = '0;
      core_key   = '0;
      if (transfer) begin
         req_ready[grant_idx] = 1'b1;
         core_state           = req_state[128*grant_idx +: 128];
         core_key             = req_key[128*grant_idx +: 128];
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (transfer) ptr_d = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      tag_valid_d  = {tag_valid_q[LATENCY-2:0], transfer};
      tag_idx_d[0] = grant_idx;
      for (int k = 1; k < LATENCY; k++) tag_idx_d[k] = tag_idx_q[k-1];
      in_flight_d = in_flight_q + CNT_W'(transfer) - CNT_W'(tag_valid_q[LATENCY-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         tag_valid_q <= '0;
         in_flight_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         tag_valid_q <= tag_valid_d;
         in_flight_q <= in_flight_d;
      end
   end

   // NOTE: tag indices mean nothing without their valid bit, so this array is left out of reset.
   always_ff @(posedge clk) begin
      tag_idx_q <= tag_idx_d;
   end

   always_comb begin
      resp_valid = '0;
      if (tag_valid_q[LATENCY-1]) resp_valid[tag_idx_q[LATENCY-1]] = 1'b1;
   end

   assign resp_data = core_out;
   assign in_flight = in_flight_q;
   assign busy      = (in_flight_q != '0);

endmodule

// File: tb/tb_aes_128_sched.sv
// Bench for aes_128_sched: a behavioural AES-128 core model feeds core_out, a reference
// arbiter queues expected responses, and a monitor pops and compares them.
module tb_aes_128_sched;
   localparam int NUM_REQ = 4;
   localparam int LATENCY = 21;
   localparam int CNT_W   = $clog2(LATENCY+1);

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   en;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*128-1:0] req_state;
   logic [NUM_REQ*128-1:0] req_key;
   logic [127:0]           core_state;
   logic [127:0]           core_key;
   logic [127:0]           core_out;
   logic [NUM_REQ-1:0]     resp_valid;
   logic [127:0]           resp_data;
   logic [CNT_W-1:0]       in_flight;
   logic                   busy;

   aes_128_sched #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_state(req_state), .req_key(req_key),
      .core_state(core_state), .core_key(core_key), .core_out(core_out),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .in_flight(in_flight), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // ---------------- behavioural AES-128 ----------------
   logic [7:0] sbox [256];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from the GF(2^8) inverse followed by the affine map.
   function automatic void init_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0]   st [16];
      logic [7:0]   rk [16];
      logic [7:0]   sb [16];
      logic [7:0]   t  [4];
      logic [7:0]   rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) begin
         rk[i] = key[127-8*i -: 8];
         st[i] = pt[127-8*i -: 8] ^ rk[i];
      end
      for (int r = 1; r <= 10; r++) begin
         t[0] = sbox[rk[13]] ^ rc; t[1] = sbox[rk[14]]; t[2] = sbox[rk[15]]; t[3] = sbox[rk[12]];
         for (int i = 0; i < 4; i++) rk[i] = rk[i] ^ t[i];
         for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
         rc = xtime(rc);
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) sb[w+4*c] = sbox[st[w+4*((c+w)%4)]];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               st[4*c]   = xtime(sb[4*c]) ^ xtime(sb[4*c+1]) ^ sb[4*c+1] ^ sb[4*c+2] ^ sb[4*c+3];
               st[4*c+1] = sb[4*c] ^ xtime(sb[4*c+1]) ^ xtime(sb[4*c+2]) ^ sb[4*c+2] ^ sb[4*c+3];
               st[4*c+2] = sb[4*c] ^ sb[4*c+1] ^ xtime(sb[4*c+2]) ^ xtime(sb[4*c+3]) ^ sb[4*c+3];
               st[4*c+3] = xtime(sb[4*c]) ^ sb[4*c] ^ sb[4*c+1] ^ sb[4*c+2] ^ xtime(sb[4*c+3]);
            end else begin
               for (int w = 0; w < 4; w++) st[4*c+w] = sb[4*c+w];
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   // Core model: captures state/key on an edge, result on out LATENCY edges later (inclusive).
   logic [127:0] core_pipe [LATENCY];
   always @(posedge clk) begin
      core_pipe[0] <= aes_enc(core_key, core_state);
      for (int k = 1; k < LATENCY; k++) core_pipe[k] <= core_pipe[k-1];
   end
   assign core_out = core_pipe[LATENCY-1];

   // ---------------- reference arbiter and scoreboard ----------------
   typedef struct {
      int           idx;
      logic [127:0] data;
      int           due;
   } exp_t;
   exp_t exp_q[$];

   initial begin : ref_model
      int m_ptr;
      int g;
      int i;
      logic [NUM_REQ-1:0] exp_ready;
      m_ptr = 0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            exp_q.delete();
            m_ptr = 0;
            continue;
         end
         g = -1;
         for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_ptr + k) % NUM_REQ;
            if (g < 0 && req_valid[i]) g = i;
         end
         if (!en) g = -1;
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         check("req_ready", req_ready, exp_ready);
         check("core_state", core_state, (g >= 0) ? req_state[128*g +: 128] : 128'h0);
         check("core_key", core_key, (g >= 0) ? req_key[128*g +: 128] : 128'h0);
         if (g >= 0) begin
            exp_q.push_back('{idx: g,
                              data: aes_enc(req_key[128*g +: 128], req_state[128*g +: 128]),
                              due: cycle + LATENCY});
            m_ptr = (g + 1) % NUM_REQ;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      logic [NUM_REQ-1:0] oh;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_resp_valid", resp_valid, 0);
            check("rst_in_flight", in_flight, 0);
            check("rst_busy", busy, 0);
            check("rst_req_ready", req_ready, 0);
            check("rst_core_state", core_state, 0);
            continue;
         end
         check("in_flight", in_flight, exp_q.size());
         check("busy", busy, exp_q.size() != 0);
         while (exp_q.size() != 0 && exp_q[0].due < cycle) begin
            e = exp_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL resp_missing: requester %0d got no response, expected at cycle %0d",
                     e.idx, e.due);
         end
         if (resp_valid != 0) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL resp_spurious: resp_valid %b with nothing expected (cycle %0d)",
                        resp_valid, cycle);
            end else begin
               e  = exp_q.pop_front();
               oh = '0;
               oh[e.idx] = 1'b1;
               check("resp_valid", resp_valid, oh);
               check("resp_data", resp_data, e.data);
               check("resp_cycle", cycle, e.due);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [127:0] k, input logic [127:0] s);
      req_key[128*i +: 128]   = k;
      req_state[128*i +: 128] = s;
   endtask

   task automatic rand_data();
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
   endtask

   task automatic expect_resp(input string name, input logic [NUM_REQ-1:0] vexp,
                              input logic [127:0] dexp, input int t_issue);
      int waited;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (resp_valid == 0 && waited < 60);
      check({name, "_valid"}, resp_valid, vexp);
      check({name, "_data"}, resp_data, dexp);
      if (t_issue >= 0) check({name, "_latency"}, cycle - t_issue, LATENCY);
   endtask

   task automatic wait_drain(input string name);
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 100) begin
         @(negedge clk);
         #2;
         waited++;
      end
      check({name, "_drain_left"}, exp_q.size(), 0);
      @(negedge clk);
      check({name, "_busy_after"}, busy, 0);
   endtask

   initial begin : stimulus
      int t0;
      int seen;
      init_sbox();
      rst_n     = 1'b0;
      en        = 1'b1;
      req_valid = '1;
      set_req(0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
      set_req(1, 128'h0, 128'h0);
      set_req(2, 128'h1, 128'h0);
      set_req(3, 128'h0, 128'h1);
      repeat (3) step();

      // Round robin straight out of reset: 0,1,2,3,0,1.
      rst_n = 1'b1;
      repeat (5) step();
      step();
      req_valid = '0;
      expect_resp("rr0", 4'b0001, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1);
      expect_resp("rr1", 4'b0010, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, -1);
      expect_resp("rr2", 4'b0100, aes_enc(128'h1, 128'h0), -1);
      expect_resp("rr3", 4'b1000, 128'h58e2fccefa7e3061367f1d57a4e7455a, -1);
      expect_resp("rr4", 4'b0001, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1);
      expect_resp("rr5", 4'b0010, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, -1);
      wait_drain("rr");

      // Single request from requester 2.
      set_req(2, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
      step();
      req_valid = 4'b0100;
      t0 = cycle;
      step();
      req_valid = '0;
      expect_resp("single", 4'b0100, 128'h3925841d02dc09fbdc118597196a0b32, t0);
      check("single_in_flight_resp", in_flight, 1);
      @(negedge clk);
      check("single_in_flight_after", in_flight, 0);

      // Wrap: requester 3 alone moves ptr to 0, then 0 beats 3.
      step(); req_valid = 4'b1000;
      @(negedge clk); check("wrap_only3", req_ready, 4'b1000);
      step(); req_valid = 4'b1001;
      @(negedge clk); check("wrap_first0", req_ready, 4'b0001);
      step(); req_valid = 4'b1000;
      @(negedge clk); check("wrap_then3", req_ready, 4'b1000);
      step(); req_valid = '0;
      wait_drain("wrap");

      // Enable gating with one block in flight, then resume from the held pointer.
      step(); req_valid = '1; en = 1'b1;
      step(); en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("gate_ready", req_ready, 0);
         check("gate_core_state", core_state, 0);
         check("gate_in_flight", in_flight, 1);
         step();
      end
      en = 1'b1;
      @(negedge clk); check("gate_resume", req_ready, 4'b0010);
      step(); req_valid = '0;
      wait_drain("gate");

      // Full pipe: 30 back-to-back issues.
      for (int k = 0; k < 30; k++) begin
         step();
         req_valid = '1;
         rand_data();
         if (k >= LATENCY) begin
            @(negedge clk);
            check("full_in_flight", in_flight, LATENCY);
         end
      end
      step(); req_valid = '0;
      wait_drain("full");

      // Reset while five blocks are in flight: none of them may ever be flagged.
      for (int k = 0; k < 5; k++) begin
         step(); req_valid = '1; rand_data();
      end
      step(); req_valid = '0;
      repeat (2) step();
      step(); rst_n = 1'b0;
      #1;
      check("midrst_in_flight", in_flight, 0);
      check("midrst_busy", busy, 0);
      repeat (3) step();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (resp_valid != 0) seen++;
      end
      check("midrst_no_resp", seen, 0);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         step();
         req_valid = NUM_REQ'($urandom);
         en        = ($urandom_range(0, 9) != 0);
         rand_data();
      end
      step(); req_valid = '0; en = 1'b1;
      wait_drain("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
